fetch_decode_stage: RTL and testbench
=====================================

Name: fetch_decode_stage

Overview:
- Front-end stage of the multi-cycle Tron datapath.
- Fetches one 16-bit instruction word from instruction memory through a request/valid handshake and latches it into the instruction register (IR).
- Splits the IR into the fields consumed downstream: the 8-bit instruction op and the 8-bit raw immediate for the sign-extend stage, plus register fields for the register file.
- Owns the program counter (PC): sequential increment, or a redirect from execute for branches and jumps.

Parameters:
- ADDR_W, 16, PC and fetch address width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  out  1  memory read request; high for exactly the one FETCH cycle.
- fetch_addr  out  ADDR_W  read address; equals the PC.
- mem_rdata  in  16  instruction word; sampled when mem_rvalid is high.
- mem_rvalid  in  1  read-data-valid strobe.
- exec_ready  in  1  execute stage accepts the decoded instruction.
- redirect_valid  in  1  branch/jump taken; meaningful only on the accept cycle.
- redirect_target  in  ADDR_W  next PC when redirect_valid is high.
- decode_valid  out  1  decoded fields are valid.
- instr_op  out  8  op code in the sign-extend encoding, e.g. ADDI=0x50, LSHI0=0x80, LSHI1=0x81, BCOND=0xC0.
- immediate  out  8  IR[7:0].
- rdest  out  4  IR[11:8]; carries the condition code for BCOND.
- rsrc  out  4  IR[3:0].
- pc_out  out  ADDR_W  PC of the instruction currently in IR.
- instr_count  out  16  count of retired (accepted) instructions.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - State = FETCH, PC = RESET_PC, IR = 0, instr_count = 0.
  - All outputs are 0 except fetch_addr and pc_out, which equal RESET_PC.
  - Reset mid-operation aborts any outstanding fetch; a late mem_rvalid after reset is ignored unless it arrives in WAIT.
- States:
  - FETCH:
    - Assert fetch_req for 1 cycle; fetch_addr = PC.
    - Move to WAIT next cycle unconditionally.
    - mem_rvalid is ignored in FETCH.
  - WAIT:
    - Hold until mem_rvalid = 1.
    - On that edge: IR <= mem_rdata, move to DECODE.
    - No timeout; waits indefinitely.
  - DECODE:
    - decode_valid = 1; all fields stay stable while exec_ready = 0.
    - On the cycle with exec_ready = 1 (accept):
      - instr_count increments, wrapping 0xFFFF -> 0.
      - PC <= redirect_valid ? redirect_target : PC+1, mod 2^ADDR_W (0xFFFF -> 0x0000).
      - Move to FETCH.
    - decode_valid drops the cycle after accept.
- Minimum latency: FETCH -> WAIT -> DECODE, i.e. 3 cycles per instruction when memory responds in the first WAIT cycle and exec_ready is already high.
- redirect_valid is ignored outside the accept cycle.
- instr_op formation, registered with IR (op = IR[15:12], ext = IR[7:4]):
  - op 0000 (R-type) or 0100 (load/store/jump): {op, ext}.
  - op 1000, IR[7:5] = 000 (LSHI): {1000, 000, IR[4]}.
  - op 1000, otherwise (LSH register): {1000, ext}.
  - All other ops (immediate forms, BCOND): {op, 0000}.
- immediate is always the raw IR[7:0]; no extension is done here.
- Fields are driven from IR combinationally; they are valid whenever decode_valid = 1 and hold their last value otherwise.

Decomposition:
- Shared package tron_pkg:
  - op localparams (ADDI, SUBI, CMPI, ANDI, LSHI0, LSHI1, BCOND, RTYPE, LDST), shared with the sign-extend stage.
  - State encoding {FETCH, WAIT, DECODE}.
- One natural sub-module: op_former (combinational IR -> instr_op).
- PC, IR, FSM and counter stay in the top module.

Test Plan:
- Reset release with RESET_PC=0, memory returns 0x5A07 one cycle after the request -> fetch_req pulses with fetch_addr 0x0000; after 3 cycles decode_valid=1, instr_op=0x50, rdest=0xA, immediate=0x07; on accept PC=0x0001 and instr_count=1.
- IR=0x8312 (LSHI) then 0x8342 (LSH register) -> instr_op=0x81 then 0x84; rsrc=2 both times.
- BCOND 0xC1FE accepted with redirect_valid=1 and target 0x0040 -> next fetch_addr=0x0040; instr_op=0xC0, rdest=0x1, immediate=0xFE.
- exec_ready held low for 5 cycles in DECODE, with mem_rdata changing and redirect_valid pulsed -> all outputs stable, PC unchanged, no extra fetch_req.
- mem_rvalid delayed 4 cycles; a spurious mem_rvalid in FETCH -> only the word present in the first WAIT-cycle mem_rvalid is latched.
- PC=0xFFFF accept without redirect -> PC wraps to 0x0000. Reset asserted in WAIT -> immediate FETCH at RESET_PC with instr_count=0.

Source files
------------

// File: rtl/tron_pkg.sv
// ============================================================================
// tron_pkg : op encodings and fetch/decode state encoding shared by the
//            Tron front-end and the sign-extend stage.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package tron_pkg;

  // instr_op values as consumed by the sign-extend stage
  localparam logic [7:0] RTYPE = 8'h00;
  localparam logic [7:0] ANDI  = 8'h10;
  localparam logic [7:0] LDST  = 8'h40;
  localparam logic [7:0] ADDI  = 8'h50;
  localparam logic [7:0] LSHI0 = 8'h80;
  localparam logic [7:0] LSHI1 = 8'h81;
  localparam logic [7:0] SUBI  = 8'h90;
  localparam logic [7:0] CMPI  = 8'hB0;
  localparam logic [7:0] BCOND = 8'hC0;

  // Major opcode (IR[15:12]) classes that keep their ext field
  localparam logic [3:0] OPC_RTYPE = 4'h0;
  localparam logic [3:0] OPC_LDST  = 4'h4;
  localparam logic [3:0] OPC_SHIFT = 4'h8;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    DECODE = 2'd2
  } fd_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_decode_stage_op_former.sv
// ============================================================================
// op_former : combinational IR -> 8-bit instr_op in the sign-extend encoding.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module op_former
  import tron_pkg::*;
(
  input  logic [15:0] ir,
  output logic [7:0]  instr_op
);

  always_comb begin
    instr_op = {ir[15:12], 4'h0};
    case (ir[15:12])
      OPC_RTYPE, OPC_LDST: instr_op = {ir[15:12], ir[7:4]};
      // Immediate shifts collapse to LSHI0/LSHI1, selected by IR[4]
      OPC_SHIFT: instr_op = (ir[7:5] == 3'b000) ? {LSHI0[7:1], ir[4]}
                                                : {ir[15:12], ir[7:4]};
      default:   instr_op = {ir[15:12], 4'h0};
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_decode_stage.sv
// ============================================================================
// fetch_decode_stage : Tron front end - PC, instruction fetch handshake,
//                      IR latch and field split for the downstream stages.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module fetch_decode_stage
  import tron_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  input  logic              exec_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              decode_valid,
  output logic [7:0]        instr_op,
  output logic [7:0]        immediate,
  output logic [3:0]        rdest,
  output logic [3:0]        rsrc,
  output logic [ADDR_W-1:0] pc_out,
  output logic [15:0]       instr_count
);

  fd_state_t         r_state;
  fd_state_t         w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_ir_pc;
  logic [15:0]       r_ir;
  logic [15:0]       r_instr_count;
  logic              w_load;
  logic              w_accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_accept     = 1'b0;
    // Gated by reset so the request stays low while the stage is held
    fetch_req    = 1'b0;
    decode_valid = 1'b0;
    case (r_state)
      FETCH: begin
        fetch_req    = ~reset;
        w_next_state = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          w_load       = 1'b1;
          w_next_state = DECODE;
        end
      end
      DECODE: begin
        decode_valid = 1'b1;
        if (exec_ready) begin
          w_accept     = 1'b1;
          w_next_state = FETCH;
        end
      end
      default: w_next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_ir_pc       <= RESET_PC;
      r_ir          <= '0;
      r_instr_count <= '0;
    end else begin
      if (w_load) begin
        r_ir    <= mem_rdata;
        r_ir_pc <= r_pc;
      end
      if (w_accept) begin
        r_instr_count <= r_instr_count + 16'd1;
        r_pc          <= redirect_valid ? redirect_target : r_pc + ADDR_W'(1);
      end
    end
  end

  op_former u_op_former (
    .ir       (r_ir),
    .instr_op (instr_op)
  );

  assign fetch_addr  = r_pc;
  assign immediate   = r_ir[7:0];
  assign rdest       = r_ir[11:8];
  assign rsrc        = r_ir[3:0];
  assign pc_out      = r_ir_pc;
  assign instr_count = r_instr_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode_stage.sv
// ============================================================================
// tb_fetch_decode_stage : randomized self-checking bench for the Tron
//                         fetch/decode stage against a behavioural model.
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        exec_ready;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        decode_valid;
  logic [7:0]  instr_op;
  logic [7:0]  immediate;
  logic [3:0]  rdest;
  logic [3:0]  rsrc;
  logic [15:0] pc_out;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model state
  logic [15:0] m_pc;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  fetch_decode_stage #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_req       (fetch_req),
    .fetch_addr      (fetch_addr),
    .mem_rdata       (mem_rdata),
    .mem_rvalid      (mem_rvalid),
    .exec_ready      (exec_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .decode_valid    (decode_valid),
    .instr_op        (instr_op),
    .immediate       (immediate),
    .rdest           (rdest),
    .rsrc            (rsrc),
    .pc_out          (pc_out),
    .instr_count     (instr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Op code derived from the instruction-class rules
  function automatic logic [7:0] expect_op(input logic [15:0] w);
    int op  = int'(w[15:12]);
    int ext = int'(w[7:4]);
    if (op == 0 || op == 4)            return 8'(op * 16 + ext);
    if (op == 8 && ext < 2)            return 8'(8'h80 + ext);
    if (op == 8)                       return 8'(op * 16 + ext);
    return 8'(op * 16);
  endfunction

  task automatic check_reset_outputs();
    check("rst_fetch_req",    {31'd0, fetch_req},    32'd0);
    check("rst_decode_valid", {31'd0, decode_valid}, 32'd0);
    check("rst_fetch_addr",   {16'd0, fetch_addr},   32'd0);
    check("rst_pc_out",       {16'd0, pc_out},       32'd0);
    check("rst_instr_count",  {16'd0, instr_count},  32'd0);
    check("rst_fields", {8'd0, instr_op, immediate, rdest, rsrc}, 32'd0);
  endtask

  // Entered at a negedge in FETCH; returns at the negedge of the next FETCH.
  task automatic do_instr(input logic [15:0] w, input int dly, input int stalls,
                          input logic spur, input logic redir, input logic [15:0] tgt);
    check("fetch_req",   {31'd0, fetch_req},    32'd1);
    check("fetch_addr",  {16'd0, fetch_addr},   {16'd0, m_pc});
    check("fetch_dv",    {31'd0, decode_valid}, 32'd0);
    mem_rvalid      = spur;
    mem_rdata       = 16'($urandom);
    exec_ready      = 1'($urandom);
    redirect_valid  = 1'($urandom);
    redirect_target = 16'($urandom);
    for (int i = 0; i <= dly; i++) begin
      @(negedge clk);
      check("wait_req", {31'd0, fetch_req},    32'd0);
      check("wait_dv",  {31'd0, decode_valid}, 32'd0);
      mem_rvalid = (i == dly);
      mem_rdata  = (i == dly) ? w : 16'($urandom);
    end
    for (int j = 0; j <= stalls; j++) begin
      @(negedge clk);
      check("dec_valid",   {31'd0, decode_valid}, 32'd1);
      check("dec_req",     {31'd0, fetch_req},    32'd0);
      check("dec_op",      {24'd0, instr_op},     {24'd0, expect_op(w)});
      check("dec_imm",     {24'd0, immediate},    {24'd0, w[7:0]});
      check("dec_regs",    {24'd0, rdest, rsrc},  {24'd0, w[11:8], w[3:0]});
      check("dec_pc_out",  {16'd0, pc_out},       {16'd0, m_pc});
      check("dec_pc",      {16'd0, fetch_addr},   {16'd0, m_pc});
      check("dec_count",   {16'd0, instr_count},  {16'd0, m_cnt});
      mem_rvalid = 1'($urandom);
      mem_rdata  = 16'($urandom);
      if (j < stalls) begin
        exec_ready      = 1'b0;
        redirect_valid  = 1'($urandom);
        redirect_target = 16'($urandom);
      end else begin
        exec_ready      = 1'b1;
        redirect_valid  = redir;
        redirect_target = tgt;
      end
    end
    m_cnt = m_cnt + 16'd1;
    m_pc  = redir ? tgt : m_pc + 16'd1;
    @(negedge clk);
    check("post_count", {16'd0, instr_count}, {16'd0, m_cnt});
    exec_ready     = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_rdata = '0; mem_rvalid = 1'b0; exec_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    m_pc = 16'h0000; m_cnt = 16'h0000;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    #1;

    do_instr(16'h5A07, 0, 0, 1'b0, 1'b0, 16'h0000);
    do_instr(16'h8312, 1, 0, 1'b1, 1'b0, 16'h0000);
    do_instr(16'h8342, 0, 2, 1'b0, 1'b0, 16'h0000);
    do_instr(16'hC1FE, 0, 0, 1'b0, 1'b1, 16'h0040);
    do_instr(16'h0123, 4, 5, 1'b1, 1'b0, 16'h0000);
    do_instr(16'h4A5B, 2, 1, 1'b0, 1'b1, 16'hFFFF);
    do_instr(16'h1234, 0, 0, 1'b0, 1'b0, 16'h0000);

    for (int k = 0; k < 40; k++) begin
      do_instr(16'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 16'($urandom));
    end

    // Reset while waiting on memory; the pending response must be dropped
    check("rr_fetch_req", {31'd0, fetch_req}, 32'd1);
    mem_rvalid = 1'b0;
    @(negedge clk);
    reset      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hBEEF;
    #1;
    check_reset_outputs();
    @(negedge clk);
    check_reset_outputs();
    reset      = 1'b0;
    mem_rvalid = 1'b0;
    m_pc       = 16'h0000;
    m_cnt      = 16'h0000;
    #1;
    do_instr(16'h9F81, 1, 1, 1'b1, 1'b0, 16'h0000);
    do_instr(16'h8001, 0, 0, 1'b0, 1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
